product_accumulator: RTL

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/mult_pkg.sv | 13 +
 rtl/rise_detect.sv | 31 +++
 rtl/product_accumulator.sv | 119 +++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state type and default widths for the multiplier/accumulator stage
package mult_pkg;

  localparam int ACC_W_DEF = 24;
  localparam int LEN_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } acc_state_e;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - registered rising-edge detector; a level already high out of reset is not an edge
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q, d_d;
  logic armed_q, armed_d;

  // armed only after the input has been seen low, so a level held across reset is ignored
  always_comb begin
    d_d     = d;
    armed_d = armed_q | ~d;
  end

  // history and arming flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q     <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      d_q     <= d_d;
      armed_q <= armed_d;
    end
  end

  assign rise = d & ~d_q & armed_q;

endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - accumulates a batch of multiplier products; ACC_SATURATE_EN selects clamping
module product_accumulator
  import mult_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [15:0]      product,
  input  logic             done,
  output logic [ACC_W-1:0] sum,
  output logic             sum_valid,
  output logic             busy,
  output logic             ovf
);

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             sum_valid_q, sum_valid_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;

  logic             done_ev;
  logic [ACC_W:0]   add_ext;
  logic [ACC_W-1:0] add_sum;
  logic [LEN_W-1:0] cnt_inc;

  rise_detect u_done_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (done),
    .rise (done_ev)
  );

  // one-bit-wider adder exposes the carry used for overflow detection
  always_comb begin
    add_ext = {1'b0, sum_q} + (ACC_W+1)'(product);
    cnt_inc = cnt_q + LEN_W'(1);
`ifdef ACC_SATURATE_EN
    add_sum = add_ext[ACC_W] ? {ACC_W{1'b1}} : add_ext[ACC_W-1:0];
`else
    add_sum = add_ext[ACC_W-1:0];
`endif
  end

  // next-state and registered-output logic for the batch FSM
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    sum_valid_d = 1'b0;
    busy_d      = busy_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACCUM;
          busy_d  = 1'b1;
          len_d   = (len == '0) ? LEN_W'(1) : len;
          cnt_d   = '0;
          sum_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_ACCUM: begin
        if (done_ev) begin
          sum_d = add_sum;
          if (add_ext[ACC_W]) ovf_d = 1'b1;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d     = ST_DONE;
            sum_valid_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      len_q       <= '0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
    end
  end

  assign sum       = sum_q;
  assign sum_valid = sum_valid_q;
  assign busy      = busy_q;
  assign ovf       = ovf_q;

endmodule
